led_status_sched: RTL and testbench

//  Status-LED scheduler for the 150 MHz DDC board. LED0 carries a fixed heartbeat.
//  LED1 is shared between NREQ status requesters (lock, overflow, config error, ...).
//  A fixed-priority arbiter picks one requester and plays its blink code on LED1:

---
 rtl/led_status_sched.sv | 174 +++++++++++++++++
 tb/tb_led_status_sched.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/led_status_sched.sv
// Status-LED scheduler: free-running tick, LED0 heartbeat, and LED1 blink codes for a fixed-priority requester.
// Optional build macro STICKY_EN latches requests until their code has played (or clr).
module led_status_sched #(
  parameter int CLK_HZ    = 150000000,
  parameter int TICK_DIV  = CLK_HZ / 10,
  parameter int HB_TICKS  = 10,
  parameter int ON_TICKS  = 2,
  parameter int OFF_TICKS = 2,
  parameter int GAP_TICKS = 10,
  parameter int NREQ      = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            clr,
  output logic            LED0,
  output logic            LED1,
  output logic            busy,
  output logic [2:0]      active_id
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

  localparam logic [27:0] TICK_LAST = 28'(TICK_DIV - 1);
  localparam logic [7:0]  HB_LAST   = 8'(HB_TICKS - 1);
  localparam logic [7:0]  ON_LAST   = 8'(ON_TICKS - 1);
  localparam logic [7:0]  OFF_LAST  = 8'(OFF_TICKS - 1);
  localparam logic [7:0]  GAP_LAST  = 8'(GAP_TICKS - 1);

  state_t          state_q, state_d;
  logic [27:0]     tick_cnt_q, tick_cnt_d;
  logic [7:0]      hb_cnt_q, hb_cnt_d;
  logic [7:0]      ph_cnt_q, ph_cnt_d;
  logic [3:0]      flash_left_q, flash_left_d;
  logic            led0_q, led0_d;
  logic            led1_q, led1_d;
  logic            busy_q, busy_d;
  logic [2:0]      active_id_q, active_id_d;
  logic [NREQ-1:0] pend;
  logic [2:0]      sel_id;
  logic            tick;
  logic            gap_done;

  assign tick = (tick_cnt_q == TICK_LAST);

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 28'd1;
    hb_cnt_d   = hb_cnt_q;
    led0_d     = led0_q;
    if (tick) begin
      if (hb_cnt_q == HB_LAST) begin
        hb_cnt_d = '0;
        led0_d   = ~led0_q;
      end else begin
        hb_cnt_d = hb_cnt_q + 8'd1;
      end
    end
  end

`ifdef STICKY_EN
  logic [NREQ-1:0] pend_q, pend_d;
  logic [NREQ-1:0] clear_mask;

  // req is OR-ed in after masking so a request coincident with a clear survives.
  always_comb begin
    clear_mask = '0;
    if (gap_done) clear_mask = NREQ'(1) << active_id_q;
    if (clr)      clear_mask = '1;
    pend_d = (pend_q & ~clear_mask) | req;
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  assign pend = pend_q | req;
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign pend       = req;
`endif

  // Highest set index wins.
  always_comb begin
    sel_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pend[i]) sel_id = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      hb_cnt_q     <= '0;
      ph_cnt_q     <= '0;
      flash_left_q <= '0;
      led0_q       <= 1'b0;
      led1_q       <= 1'b0;
      busy_q       <= 1'b0;
      active_id_q  <= '0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      hb_cnt_q     <= hb_cnt_d;
      ph_cnt_q     <= ph_cnt_d;
      flash_left_q <= flash_left_d;
      led0_q       <= led0_d;
      led1_q       <= led1_d;
      busy_q       <= busy_d;
      active_id_q  <= active_id_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ph_cnt_d     = ph_cnt_q;
    flash_left_d = flash_left_q;
    gap_done     = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (pend != '0) begin
            state_d      = S_ON;
            ph_cnt_d     = '0;
            flash_left_d = {1'b0, sel_id} + 4'd1;
          end
        end
        S_ON: begin
          if (ph_cnt_q == ON_LAST) begin
            ph_cnt_d     = '0;
            flash_left_d = flash_left_q - 4'd1;
            state_d      = S_OFF;
          end else begin
            ph_cnt_d = ph_cnt_q + 8'd1;
          end
        end
        S_OFF: begin
          if (ph_cnt_q == OFF_LAST) begin
            ph_cnt_d = '0;
            state_d  = (flash_left_q != '0) ? S_ON : S_GAP;
          end else begin
            ph_cnt_d = ph_cnt_q + 8'd1;
          end
        end
        default: begin
          if (ph_cnt_q == GAP_LAST) begin
            ph_cnt_d = '0;
            state_d  = S_IDLE;
            gap_done = 1'b1;
          end else begin
            ph_cnt_d = ph_cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_comb begin
    led1_d      = (state_d == S_ON);
    busy_d      = (state_d != S_IDLE);
    active_id_d = active_id_q;
    if (state_d == S_IDLE)                          active_id_d = '0;
    else if (state_q == S_IDLE && state_d == S_ON)  active_id_d = sel_id;
  end

  assign LED0      = led0_q;
  assign LED1      = led1_q;
  assign busy      = busy_q;
  assign active_id = active_id_q;

endmodule

// File: tb/tb_led_status_sched.sv
// Bench for led_status_sched with TICK_DIV=4: edge n is the nth clock edge after reset; tick effects land on edges 4,8,...
module tb_led_status_sched;
  localparam int NREQ = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic            clr = 1'b0;
  logic            led0, led1, busy;
  logic [2:0]      active_id;

  always #5 clk = ~clk;

  led_status_sched #(
    .TICK_DIV(4),
    .NREQ    (NREQ)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .clr      (clr),
    .LED0     (led0),
    .LED1     (led1),
    .busy     (busy),
    .active_id(active_id)
  );

  typedef struct {
    logic [NREQ-1:0] req;
    int              at_edge;
    logic            led1;
    logic            busy;
    logic [2:0]      id;
  } vec_t;

  vec_t       tbl[15];
  logic [5:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         edge_n   = 0;

  // LED0 toggles every 10 ticks = 40 edges, starting low.
  function automatic logic exp_led0(int e);
    return ((e / 40) % 2) == 1;
  endfunction

  task automatic run_to(int target);
    while (edge_n < target) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    edge_n = 0;
  endtask

  task automatic check(string name);
    logic [5:0] e, got;
    e   = exp_q.pop_front();
    got = {led0, led1, busy, active_id};
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got {led0,led1,busy,id}=%b expected %b", name, edge_n, got, e);
    end
  endtask

  task automatic expect_at(string name, int target, logic l1, logic b, logic [2:0] id);
    exp_q.push_back({exp_led0(target), l1, b, id});
    run_to(target);
    check(name);
  endtask

  initial begin
    int   rises;
    logic prev;

    // Code 1 held from reset: two flashes then OFF+GAP, repeat after the IDLE tick.
    tbl[0]  = '{4'b0010,  0, 1'b0, 1'b0, 3'd0};
    tbl[1]  = '{4'b0010,  3, 1'b0, 1'b0, 3'd0};
    tbl[2]  = '{4'b0010,  4, 1'b1, 1'b1, 3'd1};
    tbl[3]  = '{4'b0010, 11, 1'b1, 1'b1, 3'd1};
    tbl[4]  = '{4'b0010, 12, 1'b0, 1'b1, 3'd1};
    tbl[5]  = '{4'b0010, 19, 1'b0, 1'b1, 3'd1};
    tbl[6]  = '{4'b0010, 20, 1'b1, 1'b1, 3'd1};
    tbl[7]  = '{4'b0010, 28, 1'b0, 1'b1, 3'd1};
    tbl[8]  = '{4'b0010, 36, 1'b0, 1'b1, 3'd1};
    tbl[9]  = '{4'b0010, 39, 1'b0, 1'b1, 3'd1};
    tbl[10] = '{4'b0010, 40, 1'b0, 1'b1, 3'd1};
    tbl[11] = '{4'b0010, 75, 1'b0, 1'b1, 3'd1};
    tbl[12] = '{4'b0010, 76, 1'b0, 1'b0, 3'd0};
    tbl[13] = '{4'b0010, 79, 1'b0, 1'b0, 3'd0};
    tbl[14] = '{4'b0010, 80, 1'b1, 1'b1, 3'd1};

    repeat (2) @(posedge clk);
    req = 4'b0010;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      req = tbl[i].req;
      expect_at($sformatf("tbl%0d", i), tbl[i].at_edge, tbl[i].led1, tbl[i].busy, tbl[i].id);
    end

    // Code 0 running, higher request arrives mid-ON: code 0 completes first.
    req = 4'b0001;
    do_reset();
    expect_at("s3_rst", 0, 1'b0, 1'b0, 3'd0);
    expect_at("s3_on0", 4, 1'b1, 1'b1, 3'd0);
    expect_at("s3_mid", 6, 1'b1, 1'b1, 3'd0);
    req = 4'b1001;
    expect_at("s3_off0", 12, 1'b0, 1'b1, 3'd0);
    expect_at("s3_gap0", 20, 1'b0, 1'b1, 3'd0);
    expect_at("s3_gapend", 59, 1'b0, 1'b1, 3'd0);
    expect_at("s3_idle", 60, 1'b0, 1'b0, 3'd0);
    expect_at("s3_idle_wait", 63, 1'b0, 1'b0, 3'd0);
    expect_at("s3_on3", 64, 1'b1, 1'b1, 3'd3);
    expect_at("s3_off3_last", 127, 1'b0, 1'b1, 3'd3);
    expect_at("s3_gap3", 128, 1'b0, 1'b1, 3'd3);
    expect_at("s3_gap3_end", 167, 1'b0, 1'b1, 3'd3);
    expect_at("s3_idle3", 168, 1'b0, 1'b0, 3'd0);

    // Reset pulse during OFF of a 3-flash code aborts it and restarts the tick counter.
    req = 4'b0100;
    do_reset();
    expect_at("s4_on", 4, 1'b1, 1'b1, 3'd2);
    expect_at("s4_off", 13, 1'b0, 1'b1, 3'd2);
    do_reset();
    expect_at("s4_rst", 0, 1'b0, 1'b0, 3'd0);
    expect_at("s4_pre_tick", 3, 1'b0, 1'b0, 3'd0);
    expect_at("s4_on_again", 4, 1'b1, 1'b1, 3'd2);
    expect_at("s4_hb_lo", 39, 1'b1, 1'b1, 3'd2);
    expect_at("s4_hb_hi", 40, 1'b1, 1'b1, 3'd2);

    // All requesters set: only id 3 ever plays; 8 flashes start within 200 edges.
    req = 4'b1111;
    do_reset();
    rises = 0;
    prev  = 1'b0;
    for (int e = 1; e <= 200; e++) begin
      run_to(e);
      if (led1 && !prev) rises++;
      prev = led1;
      if (busy) begin
        n_checks++;
        if (active_id !== 3'd3) begin
          n_fail++;
          $display("FAIL s6_id @edge %0d: got %0d expected 3", edge_n, active_id);
        end
      end
    end
    n_checks++;
    if (rises != 8) begin
      n_fail++;
      $display("FAIL s6_flashes: got %0d expected 8", rises);
    end

`ifdef STICKY_EN
    // One-cycle pulse is latched and played once; clr with req high keeps the bit.
    req = 4'b0000;
    do_reset();
    run_to(1);
    req = 4'b0100;
    run_to(2);
    req = 4'b0000;
    expect_at("st_on", 4, 1'b1, 1'b1, 3'd2);
    expect_at("st_gap", 52, 1'b0, 1'b1, 3'd2);
    expect_at("st_idle", 92, 1'b0, 1'b0, 3'd0);
    expect_at("st_stay_idle", 96, 1'b0, 1'b0, 3'd0);
    run_to(97);
    req = 4'b0100;
    clr = 1'b1;
    run_to(98);
    req = 4'b0000;
    clr = 1'b0;
    expect_at("st_clr_req_wins", 100, 1'b1, 1'b1, 3'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
